ahb_s2m_sel_ctrl: RTL and testbench
===================================

Name: ahb_s2m_sel_ctrl

Overview:
Address decoder and data-phase select sequencer for the AHB slave-to-master response mux. Decodes the address-phase HADDR into one-hot slave selects and registers the select index into the data phase, so the mux returns the correct slave's response. Contains the bus default slave (two-cycle ERROR for unmapped transfers). Contains a stall watchdog that takes the bus back from a hung slave.

Parameters:
ADDR_WIDTH, 32, HADDR width
HSLV_NUM, 5, number of real slaves; index HSLV_NUM is the default slave
REGION_BITS, 28, log2 region size; slave index = haddr[ADDR_WIDTH-1:REGION_BITS]
TIMEOUT_CYC, 256, consecutive stalled data-phase cycles before forced error; legal range >=2
SEL_W, $clog2(HSLV_NUM+1), width of the data-phase select index

Ports:
hclk  in  1  bus clock
hresetn  in  1  asynchronous active-low reset
haddr  in  ADDR_WIDTH  address-phase address
htrans  in  2  address-phase transfer type
hready  in  1  muxed bus HREADY (s2m mux output)
tout_en_i  in  1  watchdog enable
hsel_o  out  HSLV_NUM+1  one-hot address-phase select; bit HSLV_NUM = default slave
mux_sel_o  out  SEL_W  registered data-phase slave index, drives the s2m mux select
def_hready_o  out  1  default-slave HREADYOUT into mux input HSLV_NUM
def_hresp_o  out  1  default-slave HRESP into mux input HSLV_NUM
timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- One clock hclk; reset hresetn asynchronous, active-low. All state is reset asynchronously and released synchronously to hclk.
- Reset values:
  - mux_sel_o = HSLV_NUM; def_hready_o = 1; def_hresp_o = 0; timeout_o = 0.
  - Internal: FSM = D_OK, cnt = 0, dp_active = 0.
- Decode (combinational, address only, independent of htrans):
  - idx = haddr[ADDR_WIDTH-1:REGION_BITS].
  - hsel_o[idx] = 1 if idx < HSLV_NUM; otherwise hsel_o[HSLV_NUM] = 1.
  - hsel_o is always exactly one-hot.
- Data-phase register:
  - When hready = 1: mux_sel_o <= decoded index and dp_active <= htrans[1] (NONSEQ/SEQ).
  - When hready = 0: both hold.
  - Latency: 1 cycle from the accepted address phase.
- Default-slave FSM, states D_OK, D_ERR1, D_ERR2:
  - D_OK: def_hready = 1, def_hresp = 0. Goes to D_ERR1 if hready = 1 and the address phase selects the default slave with htrans[1] = 1. IDLE/BUSY to an unmapped address gets a zero-wait OKAY.
  - D_ERR1: def_hready = 0, def_hresp = 1. Always goes to D_ERR2.
  - D_ERR2: def_hready = 1, def_hresp = 1. If a new NONSEQ/SEQ to the default slave is accepted this cycle, go to D_ERR1; else go to D_OK.
- Watchdog:
  - cnt increments each cycle with dp_active = 1, hready = 0, mux_sel_o != HSLV_NUM and tout_en_i = 1. It clears when hready = 1 or tout_en_i = 0.
  - Fires when cnt = TIMEOUT_CYC-1 and the stall persists. On the next edge: timeout_o pulses 1 cycle, mux_sel_o <= HSLV_NUM, FSM <= D_ERR1, cnt <= 0. The master then sees the two-cycle ERROR.
  - hready rising in the firing cycle wins: no timeout, normal capture.
  - The abandoned slave is not notified; system-level recovery is outside this block.
- Reset mid-transfer: all state returns to reset values immediately. The bus comes out ready (HREADY = 1 via the default slave).

Test Plan:
- Reset, then hold: mux_sel_o = 5, def_hready_o = 1, def_hresp_o = 0, timeout_o = 0 at every edge.
- NONSEQ to 0x2000_0000 with hready = 1 -> hsel_o = 6'b000100 same cycle; mux_sel_o = 2 next cycle; held while hready = 0 for 3 cycles.
- NONSEQ to 0x7000_0000 (idx 7, unmapped) -> hsel_o[5] = 1; next cycle def_hready/def_hresp = 0/1, then 1/1, then 1/0. IDLE to the same address -> 1/0 throughout.
- Back-to-back NONSEQs to unmapped addresses, second issued in the D_ERR2 cycle -> error sequence 0/1, 1/1, 0/1, 1/1 with no OKAY gap.
- TIMEOUT_CYC = 4, slave 1 holds hready = 0 indefinitely -> timeout_o pulses after 4 stalled cycles; mux_sel_o = 5; ERROR sequence follows. Repeat with hready rising in the 4th stall cycle -> no pulse, mux_sel_o updates normally.
- hresetn asserted during D_ERR1 -> outputs return to reset values asynchronously; first post-reset NONSEQ to slave 0 decodes normally.

Source files
------------

// File: rtl/ahb_s2m_sel_ctrl.sv
// ahb_s2m_sel_ctrl: AHB address decode, data-phase mux select, default slave and stall watchdog.
// Unmapped NONSEQ/SEQ transfers, and transfers whose slave stalls past the watchdog limit, end in a two-cycle ERROR.
module ahb_s2m_sel_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int HSLV_NUM    = 5,
    parameter int REGION_BITS = 28,
    parameter int TIMEOUT_CYC = 256,
    parameter int SEL_W       = $clog2(HSLV_NUM + 1)
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hready,
    input  logic                  tout_en_i,
    output logic [HSLV_NUM:0]     hsel_o,
    output logic [SEL_W-1:0]      mux_sel_o,
    output logic                  def_hready_o,
    output logic                  def_hresp_o,
    output logic                  timeout_o
);
    localparam int IDX_W = ADDR_WIDTH - REGION_BITS;
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [SEL_W-1:0] DEF_SEL = SEL_W'(HSLV_NUM);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [1:0] D_OK   = 2'd0;
    localparam logic [1:0] D_ERR1 = 2'd1;
    localparam logic [1:0] D_ERR2 = 2'd2;

    logic [IDX_W-1:0] idx;
    logic [SEL_W-1:0] dec_sel;
    logic [SEL_W-1:0] mux_sel_q, mux_sel_d;
    logic             dp_active_q, dp_active_d;
    logic [1:0]       st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tout_q;
    logic             def_acc, stall, fire;

    assign idx     = haddr[ADDR_WIDTH-1:REGION_BITS];
    assign dec_sel = ({1'b0, idx} < (IDX_W + 1)'(HSLV_NUM)) ? SEL_W'(idx) : DEF_SEL;
    assign hsel_o  = (HSLV_NUM + 1)'(1) << dec_sel;

    // Only an accepted NONSEQ/SEQ to an unmapped region earns an ERROR; IDLE/BUSY gets OKAY.
    assign def_acc = hready & htrans[1] & (dec_sel == DEF_SEL);
    assign stall   = dp_active_q & ~hready & (mux_sel_q != DEF_SEL) & tout_en_i;
    assign fire    = stall & (cnt_q == CNT_MAX);

    always_comb begin
        mux_sel_d   = fire ? DEF_SEL : (hready ? dec_sel : mux_sel_q);
        dp_active_d = hready ? htrans[1] : dp_active_q;
        cnt_d       = (stall && !fire) ? cnt_q + 1'b1 : '0;
        st_d        = fire ? D_ERR1 :
                      (st_q == D_ERR1) ? D_ERR2 :
                      def_acc ? D_ERR1 : D_OK;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            mux_sel_q   <= DEF_SEL;
            dp_active_q <= 1'b0;
            st_q        <= D_OK;
            cnt_q       <= '0;
            tout_q      <= 1'b0;
        end else begin
            mux_sel_q   <= mux_sel_d;
            dp_active_q <= dp_active_d;
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            tout_q      <= fire;
        end
    end

    assign mux_sel_o    = mux_sel_q;
    assign def_hready_o = (st_q != D_ERR1);
    assign def_hresp_o  = (st_q != D_OK);
    assign timeout_o    = tout_q;
endmodule

// File: tb/tb_ahb_s2m_sel_ctrl.sv
// tb_ahb_s2m_sel_ctrl: vector-table bench for the AHB select controller with a 4-cycle watchdog.
// Registered-output expectations are queued when a vector is driven and compared after the following edge.
module tb_ahb_s2m_sel_ctrl;
    localparam logic [1:0] ID = 2'b00;
    localparam logic [1:0] NS = 2'b10;

    typedef struct {
        logic [31:0] a;
        logic [1:0]  t;
        logic        r;
        logic        e;
        logic [5:0]  hs;
        logic [2:0]  sel;
        logic        hr;
        logic        hp;
        logic        to;
    } vec_t;

    typedef struct {
        logic [2:0] sel;
        logic       hr;
        logic       hp;
        logic       to;
    } exp_t;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = ID;
    logic        hready = 1'b1;
    logic        tout_en_i = 1'b0;
    logic [5:0]  hsel_o;
    logic [2:0]  mux_sel_o;
    logic        def_hready_o, def_hresp_o, timeout_o;

    int   n_cmp = 0;
    int   n_err = 0;
    vec_t tbl[$];
    exp_t sb[$];

    ahb_s2m_sel_ctrl #(.TIMEOUT_CYC(4)) dut (
        .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .htrans(htrans),
        .hready(hready), .tout_en_i(tout_en_i), .hsel_o(hsel_o),
        .mux_sel_o(mux_sel_o), .def_hready_o(def_hready_o),
        .def_hresp_o(def_hresp_o), .timeout_o(timeout_o)
    );

    always #5 hclk = ~hclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    function automatic vec_t v(logic [31:0] a, logic [1:0] t, logic r, logic e,
                               logic [5:0] hs, logic [2:0] sel, logic hr, logic hp, logic to);
        vec_t x;
        x.a = a; x.t = t; x.r = r; x.e = e; x.hs = hs;
        x.sel = sel; x.hr = hr; x.hp = hp; x.to = to;
        return x;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_regs(string nm, exp_t x);
        check({nm, ".mux_sel"}, 32'(mux_sel_o), 32'(x.sel));
        check({nm, ".def_hready"}, 32'(def_hready_o), 32'(x.hr));
        check({nm, ".def_hresp"}, 32'(def_hresp_o), 32'(x.hp));
        check({nm, ".timeout"}, 32'(timeout_o), 32'(x.to));
    endtask

    task automatic step(vec_t x, string nm);
        exp_t e;
        @(negedge hclk);
        haddr = x.a; htrans = x.t; hready = x.r; tout_en_i = x.e;
        #1 check({nm, ".hsel"}, 32'(hsel_o), 32'(x.hs));
        e.sel = x.sel; e.hr = x.hr; e.hp = x.hp; e.to = x.to;
        sb.push_back(e);
        @(posedge hclk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s.scoreboard: got empty queue expected entry", nm);
        end else check_regs(nm, sb.pop_front());
    endtask

    initial begin
        exp_t rst_e;
        rst_e.sel = 3'd5; rst_e.hr = 1'b1; rst_e.hp = 1'b0; rst_e.to = 1'b0;

        // reset held while a NONSEQ is driven: nothing may be captured
        haddr = 32'h2000_0000; htrans = NS; hready = 1'b1; tout_en_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge hclk);
            #1 check_regs($sformatf("rst_hold%0d", i), rst_e);
        end
        @(negedge hclk);
        hresetn = 1'b1;

        // basic decode and data-phase hold
        tbl.push_back(v(32'h0000_0000, ID, 1, 0, 6'b000001, 3'd0, 1, 0, 0));
        tbl.push_back(v(32'h2000_0000, NS, 1, 0, 6'b000100, 3'd2, 1, 0, 0));
        tbl.push_back(v(32'h0000_0000, ID, 0, 0, 6'b000001, 3'd2, 1, 0, 0));
        tbl.push_back(v(32'h0000_0000, ID, 0, 0, 6'b000001, 3'd2, 1, 0, 0));
        tbl.push_back(v(32'h0000_0000, ID, 0, 0, 6'b000001, 3'd2, 1, 0, 0));
        tbl.push_back(v(32'h0000_0000, ID, 1, 0, 6'b000001, 3'd0, 1, 0, 0));
        // unmapped NONSEQ -> ERROR; unmapped IDLE -> OKAY
        tbl.push_back(v(32'h7000_0000, NS, 1, 0, 6'b100000, 3'd5, 0, 1, 0));
        tbl.push_back(v(32'h0000_0000, ID, 0, 0, 6'b000001, 3'd5, 1, 1, 0));
        tbl.push_back(v(32'h0000_0000, ID, 1, 0, 6'b000001, 3'd0, 1, 0, 0));
        tbl.push_back(v(32'h7000_0000, ID, 1, 0, 6'b100000, 3'd5, 1, 0, 0));
        tbl.push_back(v(32'h7000_0000, ID, 1, 0, 6'b100000, 3'd5, 1, 0, 0));
        // back-to-back errors, second issued in the D_ERR2 cycle
        tbl.push_back(v(32'h9000_0000, NS, 1, 0, 6'b100000, 3'd5, 0, 1, 0));
        tbl.push_back(v(32'h0000_0000, ID, 0, 0, 6'b000001, 3'd5, 1, 1, 0));
        tbl.push_back(v(32'hF000_0000, NS, 1, 0, 6'b100000, 3'd5, 0, 1, 0));
        tbl.push_back(v(32'h0000_0000, ID, 0, 0, 6'b000001, 3'd5, 1, 1, 0));
        tbl.push_back(v(32'h1000_0000, ID, 1, 0, 6'b000010, 3'd1, 1, 0, 0));
        // slave 1 hangs: four stall cycles then forced ERROR
        tbl.push_back(v(32'h1000_0000, NS, 1, 1, 6'b000010, 3'd1, 1, 0, 0));
        tbl.push_back(v(32'h0000_0000, ID, 0, 1, 6'b000001, 3'd1, 1, 0, 0));
        tbl.push_back(v(32'h0000_0000, ID, 0, 1, 6'b000001, 3'd1, 1, 0, 0));
        tbl.push_back(v(32'h0000_0000, ID, 0, 1, 6'b000001, 3'd1, 1, 0, 0));
        tbl.push_back(v(32'h0000_0000, ID, 0, 1, 6'b000001, 3'd5, 0, 1, 1));
        tbl.push_back(v(32'h0000_0000, ID, 0, 1, 6'b000001, 3'd5, 1, 1, 0));
        tbl.push_back(v(32'h3000_0000, ID, 1, 1, 6'b001000, 3'd3, 1, 0, 0));
        // hready rises in the 4th stall cycle: normal capture, no timeout
        tbl.push_back(v(32'h1000_0000, NS, 1, 1, 6'b000010, 3'd1, 1, 0, 0));
        tbl.push_back(v(32'h0000_0000, ID, 0, 1, 6'b000001, 3'd1, 1, 0, 0));
        tbl.push_back(v(32'h0000_0000, ID, 0, 1, 6'b000001, 3'd1, 1, 0, 0));
        tbl.push_back(v(32'h0000_0000, ID, 0, 1, 6'b000001, 3'd1, 1, 0, 0));
        tbl.push_back(v(32'h4000_0000, NS, 1, 1, 6'b010000, 3'd4, 1, 0, 0));
        // watchdog disabled: long stall never fires
        for (int i = 0; i < 5; i++)
            tbl.push_back(v(32'h0000_0000, ID, 0, 0, 6'b000001, 3'd4, 1, 0, 0));
        tbl.push_back(v(32'h0000_0000, ID, 1, 1, 6'b000001, 3'd0, 1, 0, 0));

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // asynchronous reset while in D_ERR1
        step(v(32'hA000_0000, NS, 1, 0, 6'b100000, 3'd5, 0, 1, 0), "err_pre_rst");
        @(negedge hclk);
        htrans = ID; hready = 1'b0;
        #2 hresetn = 1'b0;
        #1 check_regs("async_rst", rst_e);
        @(negedge hclk);
        hresetn = 1'b1;
        step(v(32'h0000_0000, NS, 1, 0, 6'b000001, 3'd0, 1, 0, 0), "post_rst");
        step(v(32'h0000_0000, ID, 1, 0, 6'b000001, 3'd0, 1, 0, 0), "post_rst_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
